// File: rtl/dvi_rx_tmds_dec.sv
// dvi_rx_tmds_dec: per-lane TMDS word-boundary search (bitslip) and character decode.
// Stage 1 registers the raw word; token detect, decode and the lock FSM act on it; stage 2 registers outputs.
module dvi_rx_tmds_dec #(
    parameter int CTRL_RUN    = 16,
    parameter int SEARCH_WIN  = 2048,
    parameter int SLIP_SETTLE = 8
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [9:0] tmds_word,
    output logic       bitslip,
    output logic       aligned,
    output logic       den,
    output logic [1:0] ctrl,
    output logic [7:0] data
);
    localparam int WW = $clog2(SEARCH_WIN) + 1;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [9:0]      word_q;
    logic [7:0]      run_q, run_d, settle_q, settle_d;
    logic [WW-1:0]   win_q, win_d;
    logic            bitslip_q, bitslip_d, den_q, den_d;
    logic [1:0]      ctrl_q, ctrl_d, tok_val;
    logic [7:0]      data_q, data_d, q, dec;
    logic            is_tok, hit, expiry, locked;

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (word_q)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    assign q = word_q[9] ? ~word_q[7:0] : word_q[7:0];

    always_comb begin
        dec[0] = q[0];
        for (int i = 1; i < 8; i++)
            dec[i] = word_q[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
    end

    // A hit fires only on the cycle the run first reaches CTRL_RUN; a saturated run does not re-fire.
    assign hit    = is_tok && state_q != SLIP_WAIT && run_q == 8'(CTRL_RUN - 1);
    assign expiry = win_q == WW'(SEARCH_WIN - 1);
    assign locked = state_q == LOCKED;
    assign run_d  = (state_q == SLIP_WAIT || !is_tok) ? 8'd0 :
                    (run_q == 8'(CTRL_RUN) ? run_q : run_q + 8'd1);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q + 1'b1;
        settle_d  = 8'd0;
        bitslip_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (hit) begin
                    state_d = LOCKED;
                    win_d   = '0;
                end else if (expiry) begin
                    state_d   = SLIP_WAIT;
                    bitslip_d = 1'b1;
                    win_d     = '0;
                end
            end
            SLIP_WAIT: begin
                win_d    = '0;
                settle_d = settle_q + 8'd1;
                if (settle_q == 8'(SLIP_SETTLE - 1)) begin
                    state_d  = SEARCH;
                    settle_d = 8'd0;
                end
            end
            LOCKED: begin
                if (hit || expiry) begin
                    win_d   = '0;
                    state_d = hit ? LOCKED : SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign den_d  = locked && !is_tok;
    assign data_d = den_d ? dec : 8'h00;
    assign ctrl_d = !locked ? 2'b00 : (is_tok ? tok_val : ctrl_q);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            word_q    <= '0;
            run_q     <= '0;
            settle_q  <= '0;
            win_q     <= '0;
            bitslip_q <= 1'b0;
            den_q     <= 1'b0;
            ctrl_q    <= 2'b00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            word_q    <= tmds_word;
            run_q     <= run_d;
            settle_q  <= settle_d;
            win_q     <= win_d;
            bitslip_q <= bitslip_d;
            den_q     <= den_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
        end
    end

    assign bitslip = bitslip_q;
    assign aligned = locked;
    assign den     = den_q;
    assign ctrl    = ctrl_q;
    assign data    = data_q;
endmodule
